data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory slave at the MEM-stage end of the pipeline's load/store interface.
- Accepts the pipeline's read/write request and holds `stall` high while the access is in flight, so the pipeline freezes.
- Returns read data and drops `stall` after a fixed configurable latency.
- Replaces the single-cycle combinational data memory when realistic memory timing is modelled.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array (power of 2).
- LATENCY, 3, cycles from request acceptance to completion (>= 1).
- CNT_W, 16, width of the access counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  load request from MEM stage.
- mem_write  in  1  store request from MEM stage.
- addr  in  32  byte address; word index = addr[log2(DEPTH_WORDS)+1:2].
- wdata  in  32  store data.
- rdata  out  32  load data, registered.
- stall  out  1  high while an access is pending; pipeline holds all stages.
- rd_cnt  out  CNT_W  completed reads, wraps.
- wr_cnt  out  CNT_W  completed writes, wraps.

Behaviour:
- States: IDLE, BUSY, DONE. Reset values: IDLE, rdata=0, rd_cnt=0, wr_cnt=0, internal down-counter=0.
- Array contents are not reset.
- Request = mem_read | mem_write.
- If both are high, it is a write; rdata is not updated.
- addr[1:0] are ignored.
- Indices beyond DEPTH_WORDS wrap by truncation.
- IDLE with request at cycle t:
  - Capture type, index and wdata.
  - LATENCY=1: go to DONE.
  - LATENCY>1: go to BUSY with cnt=LATENCY-1.
- BUSY:
  - cnt==1 -> DONE.
  - Otherwise cnt decrements.
  - Inputs are ignored; the captured values are used.
- Completion happens on the edge entering DONE:
  - Write: commits the captured wdata to the array; wr_cnt++.
  - Read: rdata <= array[captured index]; rd_cnt++.
- DONE lasts 1 cycle, then IDLE unconditionally.
  - The inputs still show the completed request during DONE; they are not re-accepted.
- stall (combinational) = (state==IDLE & request) | (state==BUSY).
  - It is high for cycles t..t+LATENCY-1 and low at t+LATENCY (DONE). The pipeline advances at the end of DONE.
  - It is forced to 0 while rst is low.
- Back-to-back accesses: a new request is accepted in the IDLE cycle after DONE.
  - Each access costs LATENCY stall cycles plus 1 DONE cycle.
- No request in IDLE: stall=0, rdata holds its last value, counters hold.
- rdata holds the last completed read value across writes and idle cycles.
- Counters wrap from 2^CNT_W-1 to 0.
- Reset mid-access: immediately go to IDLE, stall=0.
  - A pending write is discarded (array unchanged).
  - A pending read does not update rdata.
  - Counters clear.
- A read of an address never written returns X; the bench writes before reading.

Test Plan:
- LATENCY=3, write addr=0x10, wdata=0xDEADBEEF at t -> stall=1 for t..t+2, 0 at t+3; wr_cnt=1 after t+3.
- Then read addr=0x10 -> rdata=0xDEADBEEF from t'+3, stall low at t'+3 only; rd_cnt=1.
- mem_read=mem_write=1, addr=0x20, wdata=0x12345678 -> treated as write; rdata unchanged. A following read of 0x20 returns 0x12345678.
- Write 0xA5A5A5A5 to addr=0x0, then read addr=4*DEPTH_WORDS (0x1000) -> wraps to index 0, rdata=0xA5A5A5A5. A read of addr=0x3 also returns 0xA5A5A5A5.
- Start write 0x11111111 to 0x40, assert rst low at t+1 -> stall=0 immediately, wr_cnt=0. After release, read 0x40 returns its prior value (0x0 if written beforehand), not 0x11111111.
- LATENCY=1 back-to-back: 4 reads with request held high -> stall pattern 1,0,1,0,...; rd_cnt=4 after 8 cycles.
- Change addr/wdata during BUSY -> the captured values are used.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory slave: accepts a load/store, holds stall for LATENCY cycles, completes on entry to DONE.
// Latency LATENCY cycles + 1 DONE cycle per access; no backpressure beyond stall, inputs ignored while busy.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             stall,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_is_wr;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_req;
  logic            w_accept;
  logic            w_complete;
  logic            w_cmp_wr;
  logic [AW-1:0]   w_in_idx;
  logic [AW-1:0]   w_cmp_idx;
  logic [31:0]     w_cmp_dat;
  logic            w_unused_addr;

  assign w_req         = mem_read | mem_write;
  assign w_in_idx      = addr[AW+1:2];
  assign w_unused_addr = ^{addr[31:AW+2], addr[1:0]};
  assign w_accept      = (r_state == IDLE) && w_req;

  // With LATENCY=1 the access completes on its acceptance edge, so the live inputs are used.
  assign w_complete = ((r_state == BUSY) && (r_cnt == CW'(1))) || (w_accept && (LATENCY == 1));
  assign w_cmp_wr   = (r_state == IDLE) ? mem_write : r_is_wr;
  assign w_cmp_idx  = (r_state == IDLE) ? w_in_idx  : r_idx;
  assign w_cmp_dat  = (r_state == IDLE) ? wdata     : r_wdata;

  assign stall = rst & (w_accept | (r_state == BUSY));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_is_wr <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      rdata   <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_is_wr <= mem_write;
            r_idx   <= w_in_idx;
            r_wdata <= wdata;
            if (LATENCY == 1) begin
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CW'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (r_cnt == CW'(1)) begin
            r_state <= DONE;
          end
          r_cnt <= r_cnt - CW'(1);
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_complete) begin
        if (w_cmp_wr) begin
          wr_cnt <= wr_cnt + CNT_W'(1);
        end else begin
          rdata  <= r_mem[w_cmp_idx];
          rd_cnt <= rd_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Array is never reset; gating on rst drops a write whose completion edge lands in reset.
  always_ff @(posedge clk) begin
    if (rst && w_complete && w_cmp_wr) begin
      r_mem[w_cmp_idx] <= w_cmp_dat;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY=3 (16-bit counters) and LATENCY=1 (3-bit counters)
// sharing one request stream, checked every cycle against a timeline model plus literal expectations.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rdata3, rdata1;
  logic        stall3, stall1;
  logic [15:0] rd_cnt3, wr_cnt3;
  logic [2:0]  rd_cnt1, wr_cnt1;

  int n_vec = 0;
  int n_bad = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata3), .stall(stall3),
    .rd_cnt(rd_cnt3), .wr_cnt(wr_cnt3)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .CNT_W(3)) u_dut1 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata1), .stall(stall1),
    .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
  );

  always #5 clk = ~clk;

  // Timeline model: an access accepted in cycle a stalls cycles a..a+L-1,
  // completes at the end of cycle a+L-1, and cycle a+L is the idle-only DONE cycle.
  int          lat [2]     = '{3, 1};
  int          acc [2]     = '{-1, -1};
  bit          m_wr [2];
  int          m_idx [2];
  logic [31:0] m_dat [2];
  logic [31:0] e_rdata [2] = '{32'h0, 32'h0};
  int          e_rd [2]    = '{0, 0};
  int          e_wr [2]    = '{0, 0};
  logic [31:0] mem [int];
  int          cyc = 0;

  function automatic logic exp_stall(int d);
    if (!rst) return 1'b0;
    if (acc[d] >= 0 && cyc < acc[d] + lat[d]) return 1'b1;
    if (acc[d] >= 0 && cyc == acc[d] + lat[d]) return 1'b0;
    return mem_read | mem_write;
  endfunction

  always @(negedge rst) begin
    for (int d = 0; d < 2; d++) begin
      acc[d]     = -1;
      e_rd[d]    = 0;
      e_wr[d]    = 0;
      e_rdata[d] = 32'h0;
    end
  end

  always @(posedge clk) begin
    int k;
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        if (acc[d] < 0) begin
          if (mem_read | mem_write) begin
            acc[d]   = cyc;
            m_wr[d]  = mem_write;
            m_idx[d] = int'(addr[11:2]);
            m_dat[d] = wdata;
          end
        end else if (cyc == acc[d] + lat[d]) begin
          acc[d] = -1;
        end
        if (acc[d] >= 0 && cyc == acc[d] + lat[d] - 1) begin
          k = d * 1024 + m_idx[d];
          if (m_wr[d]) begin
            mem[k] = m_dat[d];
            e_wr[d]++;
          end else begin
            e_rdata[d] = mem.exists(k) ? mem[k] : 32'hx;
            e_rd[d]++;
          end
        end
      end
    end
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    chk("stall3",  32'(stall3),  32'(exp_stall(0)));
    chk("rdata3",  rdata3,       e_rdata[0]);
    chk("rd_cnt3", 32'(rd_cnt3), 32'(e_rd[0] % 65536));
    chk("wr_cnt3", 32'(wr_cnt3), 32'(e_wr[0] % 65536));
    chk("stall1",  32'(stall1),  32'(exp_stall(1)));
    chk("rdata1",  rdata1,       e_rdata[1]);
    chk("rd_cnt1", 32'(rd_cnt1), 32'(e_rd[1] % 8));
    chk("wr_cnt1", 32'(wr_cnt1), 32'(e_wr[1] % 8));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One LATENCY=3 access: request held 4 cycles, addr/wdata switched to a2/d2 after acceptance.
  task automatic do_acc(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] a2, input logic [31:0] d2,
                        output logic [3:0] pat, output logic [31:0] rd_done);
    mem_read  = r;
    mem_write = w;
    addr      = a;
    wdata     = d;
    pat       = '0;
    rd_done   = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pat[3-i] = stall3;
      if (i == 3) rd_done = rdata3;
      tick();
      if (i == 0) begin
        addr  = a2;
        wdata = d2;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    logic [3:0]  pat;
    logic [31:0] rd;
    logic [7:0]  pat8;

    #1 rst = 1'b0;
    tick();
    @(negedge clk);
    chk("reset_stall", 32'(stall3), 32'h0);
    chk("reset_rdata", rdata3, 32'h0);
    chk("reset_rd_cnt", 32'(rd_cnt3), 32'h0);
    chk("reset_wr_cnt", 32'(wr_cnt3), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    do_acc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h10, 32'hDEADBEEF, pat, rd);
    chk("wr_stall_pattern", 32'(pat), 32'hE);
    @(negedge clk);
    chk("wr_cnt_after_write", 32'(wr_cnt3), 32'h1);
    tick();

    do_acc(1'b1, 1'b0, 32'h10, 32'h0, 32'h10, 32'h0, pat, rd);
    chk("rd_stall_pattern", 32'(pat), 32'hE);
    chk("rd_data_at_done", rd, 32'hDEADBEEF);
    chk("rd_cnt_after_read", 32'(rd_cnt3), 32'h1);

    do_acc(1'b1, 1'b1, 32'h20, 32'h12345678, 32'h20, 32'h12345678, pat, rd);
    chk("both_high_rdata_held", rd, 32'hDEADBEEF);
    chk("both_high_counts_write", 32'(wr_cnt3), 32'h2);
    do_acc(1'b1, 1'b0, 32'h20, 32'h0, 32'h20, 32'h0, pat, rd);
    chk("read_after_both_high", rd, 32'h12345678);

    do_acc(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, pat, rd);
    do_acc(1'b1, 1'b0, 32'h1000, 32'h0, 32'h1000, 32'h0, pat, rd);
    chk("index_wrap_read", rd, 32'hA5A5A5A5);
    do_acc(1'b1, 1'b0, 32'h3, 32'h0, 32'h3, 32'h0, pat, rd);
    chk("byte_offset_ignored", rd, 32'hA5A5A5A5);

    do_acc(1'b0, 1'b1, 32'h40, 32'h0, 32'h40, 32'h0, pat, rd);
    mem_write = 1'b1;
    addr      = 32'h40;
    wdata     = 32'h11111111;
    @(negedge clk);
    chk("pre_reset_stall", 32'(stall3), 32'h1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_stall", 32'(stall3), 32'h0);
    chk("mid_reset_wr_cnt", 32'(wr_cnt3), 32'h0);
    tick();
    rst       = 1'b1;
    mem_write = 1'b0;
    tick();
    do_acc(1'b1, 1'b0, 32'h40, 32'h0, 32'h40, 32'h0, pat, rd);
    chk("discarded_write", rd, 32'h0);

    do_acc(1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 32'h84, 32'hBAADBAAD, pat, rd);
    do_acc(1'b1, 1'b0, 32'h80, 32'h0, 32'h80, 32'h0, pat, rd);
    chk("captured_wdata_addr", rd, 32'hCAFEF00D);
    do_acc(1'b1, 1'b0, 32'h10, 32'h0, 32'h20, 32'h0, pat, rd);
    chk("captured_read_addr", rd, 32'hDEADBEEF);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    mem_read = 1'b1;
    addr     = 32'h10;
    pat8     = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i < 8) pat8[7-i] = stall1;
      if (i == 7) chk("lat1_rd_cnt_after_8", 32'(rd_cnt1), 32'h4);
      if (i == 19) begin
        chk("lat1_rd_cnt_wrap", 32'(rd_cnt1), 32'h2);
        chk("lat1_rdata", rdata1, 32'hDEADBEEF);
      end
      tick();
    end
    chk("lat1_stall_pattern", 32'(pat8), 32'hAA);
    mem_read = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
